ofs_pcie_ep_tag_pool: RTL and testbench

OFS_PCIE_EP_TAG_POOL -- requirements
Module: ofs_pcie_ep_tag_pool

---
 rtl/ofs_pcie_ss_cfg_pkg.sv | 4 +
 rtl/ofs_pcie_ep_tag_pool.sv | 83 ++++++++
 tb/tb_ofs_pcie_ep_tag_pool.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// ofs_pcie_ss_cfg_pkg: PCIe subsystem configuration constants.
package ofs_pcie_ss_cfg_pkg;
   parameter int PCIE_EP_MAX_TAGS = 64;
endpackage

// File: rtl/ofs_pcie_ep_tag_pool.sv
// ofs_pcie_ep_tag_pool: FPGA->host read tag allocator built from a free-list FIFO
// and a busy bitmap; the FIFO is filled with every tag once after reset.
module ofs_pcie_ep_tag_pool #(
   parameter int NUM_TAGS = ofs_pcie_ss_cfg_pkg::PCIE_EP_MAX_TAGS,
   parameter int TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             alloc_valid,
   input  logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             free_valid,
   input  logic [TAG_W-1:0] free_tag,
   output logic [TAG_W:0]   busy_cnt,
   output logic             init_done,
   output logic             err_bad_free
);
   localparam int PW = $clog2(NUM_TAGS);
   localparam logic [TAG_W:0] N_T  = (TAG_W+1)'(NUM_TAGS);
   localparam logic [PW-1:0]  LAST = PW'(NUM_TAGS-1);

   typedef enum logic {INIT, RUN} state_t;
   state_t              state_q, state_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]         cnt_q, cnt_d;
   logic [NUM_TAGS-1:0] busy_q, busy_d;
   logic [TAG_W:0]      busy_cnt_q, busy_cnt_d;
   logic                err_q, err_d;
   logic [TAG_W-1:0]    mem_q [NUM_TAGS];
   logic                run, push, pop, free_ok;
   logic [TAG_W-1:0]    push_tag;
   logic [PW-1:0]       free_idx, head_idx;

   always_comb begin
      run         = state_q == RUN;
      alloc_valid = run && cnt_q != '0;
      alloc_tag   = mem_q[rd_ptr_q];
      head_idx    = alloc_tag[PW-1:0];
      free_idx    = free_tag[PW-1:0];
      pop         = alloc_valid && alloc_ready;
      // the range test guards the bitmap lookup for tags beyond the pool
      free_ok     = run && free_valid && ({1'b0, free_tag} < N_T) && busy_q[free_idx];
      push        = !run || free_ok;
      push_tag    = run ? free_tag : TAG_W'(wr_ptr_q);
      wr_ptr_d    = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d    = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      cnt_d       = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      busy_d      = busy_q;
      if (pop) busy_d[head_idx] = 1'b1;
      if (free_ok) busy_d[free_idx] = 1'b0;
      busy_cnt_d  = busy_cnt_q + (TAG_W+1)'(pop) - (TAG_W+1)'(free_ok);
      err_d       = err_q || (free_valid && !free_ok);
      state_d     = (!run && wr_ptr_q == LAST) ? RUN : state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_tag;
   end

   assign busy_cnt     = busy_cnt_q;
   assign init_done    = run;
   assign err_bad_free = err_q;
endmodule

// File: tb/tb_ofs_pcie_ep_tag_pool.sv
// tb_ofs_pcie_ep_tag_pool: directed stimulus with a queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_ofs_pcie_ep_tag_pool;
   localparam int N = 8;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          alloc_valid, alloc_ready, free_valid, init_done, err_bad_free;
   logic [TW-1:0] alloc_tag, free_tag;
   logic [TW:0]   busy_cnt;

   int checks = 0;
   int passed = 0;

   ofs_pcie_ep_tag_pool #(.NUM_TAGS(N), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .free_valid(free_valid), .free_tag(free_tag),
      .busy_cnt(busy_cnt), .init_done(init_done), .err_bad_free(err_bad_free)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   int m_q[$];
   bit m_busy[16];
   int m_cnt, m_init, m_head;
   bit m_run, m_err, m_av, m_fire, m_legal;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_cnt = 0; m_init = 0; m_run = 0; m_err = 0;
      end else if (!m_run) begin
         if (free_valid) m_err = 1;
         m_q.push_back(m_init);
         m_init++;
         if (m_init == N) m_run = 1;
      end else begin
         m_av    = m_q.size() > 0;
         m_fire  = m_av && alloc_ready;
         m_head  = m_av ? m_q[0] : 0;
         m_legal = free_valid && int'(free_tag) < N && m_busy[free_tag];
         if (m_fire) begin
            void'(m_q.pop_front());
            m_busy[m_head] = 1;
            m_cnt++;
         end
         if (m_legal) begin
            m_q.push_back(int'(free_tag));
            m_busy[free_tag] = 0;
            m_cnt--;
         end else if (free_valid) m_err = 1;
      end
   end

   always @(negedge clk) begin
      chk("m_alloc_valid", alloc_valid, int'(m_run && m_q.size() > 0));
      if (m_run && m_q.size() > 0) chk("m_alloc_tag", alloc_tag, m_q[0]);
      chk("m_busy_cnt", busy_cnt, m_cnt);
      chk("m_init_done", init_done, m_run);
      chk("m_err_bad_free", err_bad_free, m_err);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      alloc_ready = 0; free_valid = 0; free_tag = '0;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_av", alloc_valid, 0);
      chk("rst_busy", busy_cnt, 0);
      chk("rst_init", init_done, 0);
      chk("rst_err", err_bad_free, 0);
      rst_n = 1;
      #1 chk("init_av", alloc_valid, 0);
      repeat (7) begin
         @(negedge clk);
         chk("init_av", alloc_valid, 0);
         chk("init_done_lo", init_done, 0);
      end
      @(negedge clk);
      chk("init_done_hi", init_done, 1);
      chk("first_av", alloc_valid, 1);
      chk("first_tag", alloc_tag, 0);
      alloc_ready = 1;
      for (int i = 0; i < N; i++) begin
         chk("seq_tag", alloc_tag, i);
         chk("seq_av", alloc_valid, 1);
         @(negedge clk);
      end
      alloc_ready = 0;
      chk("full_av", alloc_valid, 0);
      chk("full_busy", busy_cnt, 8);
      free_valid = 1; free_tag = 5;
      @(negedge clk);
      free_valid = 0;
      chk("refree_av", alloc_valid, 1);
      chk("refree_tag", alloc_tag, 5);
      chk("refree_busy", busy_cnt, 7);
      alloc_ready = 1;
      @(negedge clk);
      alloc_ready = 0;
      chk("refull_busy", busy_cnt, 8);
      free_valid = 1; free_tag = 0;
      @(negedge clk);
      alloc_ready = 1; free_tag = 3;
      @(negedge clk);
      alloc_ready = 0; free_valid = 0;
      chk("both_busy", busy_cnt, 7);
      chk("both_tag", alloc_tag, 3);
      free_valid = 1; free_tag = 9;
      @(negedge clk);
      free_valid = 0;
      chk("oor_err", err_bad_free, 1);
      chk("oor_busy", busy_cnt, 7);
      free_valid = 1; free_tag = 2;
      @(negedge clk);
      @(negedge clk);
      free_valid = 0;
      chk("dup_busy", busy_cnt, 6);
      chk("dup_err", err_bad_free, 1);
      chk("dup_head", alloc_tag, 3);
      alloc_ready = 1; free_valid = 1; free_tag = 3;
      @(negedge clk);
      alloc_ready = 0; free_valid = 0;
      chk("selffree_busy", busy_cnt, 7);
      chk("selffree_tag", alloc_tag, 2);
      #2 rst_n = 0;
      #1;
      chk("arst_av", alloc_valid, 0);
      chk("arst_busy", busy_cnt, 0);
      chk("arst_init", init_done, 0);
      chk("arst_err", err_bad_free, 0);
      @(negedge clk);
      rst_n = 1; free_valid = 1; free_tag = 4;
      @(negedge clk);
      free_valid = 0;
      repeat (6) @(negedge clk);
      @(negedge clk);
      chk("reinit_done", init_done, 1);
      chk("reinit_tag", alloc_tag, 0);
      chk("reinit_err", err_bad_free, 1);
      alloc_ready = 1;
      for (int i = 0; i < 2; i++) begin
         chk("reseq_tag", alloc_tag, i);
         @(negedge clk);
      end
      alloc_ready = 0;
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
